// File: rtl/dma_channel_regfile_if.sv
// CPU programming bus of the DMA channel register file: chip select, strobes,
// register address {G, ch, r} and the byte-wide data paths.
interface dma_channel_regfile_if #(
  parameter int NUM_CH = 4
) ();
  localparam int AWID = $clog2(NUM_CH) + 3;

  logic            CS_N;
  logic            IOR_N;
  logic            IOW_N;
  logic [AWID-1:0] A;
  logic [7:0]      DIN;
  logic [7:0]      DOUT;

  modport master (output CS_N, IOR_N, IOW_N, A, DIN, input DOUT);
  modport slave  (input CS_N, IOR_N, IOW_N, A, DIN, output DOUT);
endinterface

// File: rtl/dma_channel_regfile.sv
// Multi-channel DMA register file: byte-serial CPU programming of base/current
// address and count, per-transfer address stepping and terminal-count handling.
module dma_channel_regfile #(
  parameter int  NUM_CH = 4,
  parameter int  AW     = 16,
  parameter int  CW     = 16,
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  dma_channel_regfile_if.slave bus,
  input  logic [CHW-1:0]       CH_SEL,
  input  logic                 XFER,
  output logic [AW-1:0]        CUR_ADDR,
  output logic [NUM_CH-1:0]    CH_EN,
  output logic [NUM_CH-1:0]    TC,
  output logic                 EOP
);
  localparam int AWID = $clog2(NUM_CH) + 3;
  localparam int NB   = ((AW > CW) ? AW : CW) / 8;
  localparam int BPW  = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CHW:0]   NUM_CH_L = (CHW+1)'(NUM_CH);
  localparam logic [BPW:0]   AB_L     = (BPW+1)'(AW / 8);
  localparam logic [BPW:0]   CB_L     = (BPW+1)'(CW / 8);
  localparam logic [BPW-1:0] BP_LAST  = BPW'(NB - 1);

  logic [AW-1:0]     baseAddr_r [NUM_CH];
  logic [AW-1:0]     curAddr_r  [NUM_CH];
  logic [CW-1:0]     baseCnt_r  [NUM_CH];
  logic [CW-1:0]     curCnt_r   [NUM_CH];
  logic [NUM_CH-1:0] autoinit_r, decr_r, chEn_r, tc_r;
  logic [BPW-1:0]    bp_r;
  logic [7:0]        dout_r;
  logic              eop_r;

  logic              rdEn_s, wrEn_s, glob_s, chOk_s, byteAcc_s;
  logic              addrWr_s, cntWr_s, modeWr_s, statusRd_s, bpClr_s, mclr_s;
  logic [1:0]        reg_s;
  logic [CHW-1:0]    cpuCh_s;
  logic [AW-1:0]     cpuCurAddr_s, cpuBaseAddr_s, newCurAddr_s, newBaseAddr_s;
  logic [CW-1:0]     cpuCurCnt_s, cpuBaseCnt_s, newCurCnt_s, newBaseCnt_s;
  logic              cpuAuto_s, cpuDecr_s;
  logic [7:0]        addrByte_s, cntByte_s, rdByte_s;
  logic              selOk_s, xEn_s, xDecr_s, xferOk_s, tcHit_s;
  logic [AW-1:0]     xAddr_s, xStepAddr_s;
  logic [CW-1:0]     xCnt_s;
  logic [NUM_CH-1:0] tcSet_s, chEnNext_s;

  // Simultaneous read and write strobes are treated as no access at all.
  assign rdEn_s  = ~bus.CS_N & ~bus.IOR_N &  bus.IOW_N;
  assign wrEn_s  = ~bus.CS_N & ~bus.IOW_N &  bus.IOR_N;
  assign glob_s  = bus.A[AWID-1];
  assign reg_s   = bus.A[1:0];

  generate
    if (NUM_CH > 1) begin : gChField
      assign cpuCh_s = bus.A[AWID-2:2];
    end else begin : gChSingle
      assign cpuCh_s = 1'b0;
    end
  endgenerate

  assign chOk_s     = ~glob_s & ({1'b0, cpuCh_s} < NUM_CH_L);
  assign byteAcc_s  = (rdEn_s | wrEn_s) & chOk_s & ~reg_s[1];
  assign addrWr_s   = wrEn_s & chOk_s & (reg_s == 2'd0) & ({1'b0, bp_r} < AB_L);
  assign cntWr_s    = wrEn_s & chOk_s & (reg_s == 2'd1) & ({1'b0, bp_r} < CB_L);
  assign modeWr_s   = wrEn_s & chOk_s & (reg_s == 2'd2);
  assign statusRd_s = rdEn_s & glob_s & (reg_s == 2'd0);
  assign bpClr_s    = wrEn_s & glob_s & (reg_s == 2'd1);
  assign mclr_s     = wrEn_s & glob_s & (reg_s == 2'd2);

  assign selOk_s     = {1'b0, CH_SEL} < NUM_CH_L;
  assign xferOk_s    = XFER & selOk_s & xEn_s;
  assign tcHit_s     = xferOk_s & (xCnt_s == '0);
  assign xStepAddr_s = xDecr_s ? (xAddr_s - AW'(1)) : (xAddr_s + AW'(1));

  // Channel muxes for the CPU-addressed channel and the serviced channel.
  always_comb begin
    cpuCurAddr_s  = '0;
    cpuBaseAddr_s = '0;
    cpuCurCnt_s   = '0;
    cpuBaseCnt_s  = '0;
    cpuAuto_s     = 1'b0;
    cpuDecr_s     = 1'b0;
    xAddr_s       = '0;
    xCnt_s        = '0;
    xEn_s         = 1'b0;
    xDecr_s       = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      cpuCurAddr_s  |= (cpuCh_s == CHW'(c)) ? curAddr_r[c]  : '0;
      cpuBaseAddr_s |= (cpuCh_s == CHW'(c)) ? baseAddr_r[c] : '0;
      cpuCurCnt_s   |= (cpuCh_s == CHW'(c)) ? curCnt_r[c]   : '0;
      cpuBaseCnt_s  |= (cpuCh_s == CHW'(c)) ? baseCnt_r[c]  : '0;
      cpuAuto_s     |= (cpuCh_s == CHW'(c)) & autoinit_r[c];
      cpuDecr_s     |= (cpuCh_s == CHW'(c)) & decr_r[c];
      xAddr_s       |= (CH_SEL == CHW'(c)) ? curAddr_r[c] : '0;
      xCnt_s        |= (CH_SEL == CHW'(c)) ? curCnt_r[c]  : '0;
      xEn_s         |= (CH_SEL == CHW'(c)) & chEn_r[c];
      xDecr_s       |= (CH_SEL == CHW'(c)) & decr_r[c];
    end
  end

  // Byte-pointer selection for readback and byte-merge for CPU writes.
  always_comb begin
    addrByte_s    = 8'h00;
    cntByte_s     = 8'h00;
    newCurAddr_s  = cpuCurAddr_s;
    newBaseAddr_s = cpuBaseAddr_s;
    newCurCnt_s   = cpuCurCnt_s;
    newBaseCnt_s  = cpuBaseCnt_s;
    for (int b = 0; b < AW / 8; b++) begin
      addrByte_s |= (bp_r == BPW'(b)) ? cpuCurAddr_s[8*b +: 8] : 8'h00;
      newCurAddr_s[8*b +: 8]  = (bp_r == BPW'(b)) ? bus.DIN : cpuCurAddr_s[8*b +: 8];
      newBaseAddr_s[8*b +: 8] = (bp_r == BPW'(b)) ? bus.DIN : cpuBaseAddr_s[8*b +: 8];
    end
    for (int b = 0; b < CW / 8; b++) begin
      cntByte_s |= (bp_r == BPW'(b)) ? cpuCurCnt_s[8*b +: 8] : 8'h00;
      newCurCnt_s[8*b +: 8]  = (bp_r == BPW'(b)) ? bus.DIN : cpuCurCnt_s[8*b +: 8];
      newBaseCnt_s[8*b +: 8] = (bp_r == BPW'(b)) ? bus.DIN : cpuBaseCnt_s[8*b +: 8];
    end
  end

  // CPU read data mux.
  always_comb begin
    rdByte_s = 8'h00;
    if (glob_s) begin
      rdByte_s = (reg_s == 2'd0) ? 8'(tc_r) : 8'h00;
    end else if (chOk_s) begin
      case (reg_s)
        2'd0:    rdByte_s = addrByte_s;
        2'd1:    rdByte_s = cntByte_s;
        2'd2:    rdByte_s = {6'b000000, cpuDecr_s, cpuAuto_s};
        default: rdByte_s = 8'h00;
      endcase
    end else begin
      rdByte_s = 8'h00;
    end
  end

  // Terminal-count set vector and next channel enables; master clear dominates.
  always_comb begin
    tcSet_s    = '0;
    chEnNext_s = chEn_r;
    for (int c = 0; c < NUM_CH; c++) begin
      tcSet_s[c]    = tcHit_s & (CH_SEL == CHW'(c));
      chEnNext_s[c] = mclr_s                                 ? 1'b0 :
                      (modeWr_s & (cpuCh_s == CHW'(c)))      ? 1'b1 :
                      (tcSet_s[c] & ~autoinit_r[c])          ? 1'b0 : chEn_r[c];
    end
  end

  // Per-channel address/count/mode state; a CPU byte write overrides XFER on its register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int c = 0; c < NUM_CH; c++) begin
        baseAddr_r[c] <= '0;
        curAddr_r[c]  <= '0;
        baseCnt_r[c]  <= '0;
        curCnt_r[c]   <= '0;
      end
      autoinit_r <= '0;
      decr_r     <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (xferOk_s && (CH_SEL == CHW'(c))) begin
          if (tcHit_s && autoinit_r[c]) begin
            curAddr_r[c] <= baseAddr_r[c];
            curCnt_r[c]  <= baseCnt_r[c];
          end else begin
            curAddr_r[c] <= xStepAddr_s;
            curCnt_r[c]  <= xCnt_s - CW'(1);
          end
        end
        if (cpuCh_s == CHW'(c)) begin
          if (addrWr_s) begin
            baseAddr_r[c] <= newBaseAddr_s;
            curAddr_r[c]  <= newCurAddr_s;
          end
          if (cntWr_s) begin
            baseCnt_r[c] <= newBaseCnt_s;
            curCnt_r[c]  <= newCurCnt_s;
          end
          if (modeWr_s) begin
            autoinit_r[c] <= bus.DIN[0];
            decr_r[c]     <= bus.DIN[1];
          end
        end
      end
    end
  end

  // Byte pointer, status flags, enables, read data and end-of-process pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bp_r   <= '0;
      tc_r   <= '0;
      chEn_r <= '0;
      dout_r <= 8'h00;
      eop_r  <= 1'b0;
    end else begin
      if (mclr_s || bpClr_s) begin
        bp_r <= '0;
      end else if (byteAcc_s) begin
        bp_r <= (bp_r == BP_LAST) ? '0 : bp_r + BPW'(1);
      end
      // A flag set on the status-read edge must survive the clear.
      if (mclr_s) begin
        tc_r <= '0;
      end else if (statusRd_s) begin
        tc_r <= tcSet_s;
      end else begin
        tc_r <= tc_r | tcSet_s;
      end
      chEn_r <= chEnNext_s;
      if (rdEn_s) begin
        dout_r <= rdByte_s;
      end
      eop_r <= tcHit_s;
    end
  end

  assign bus.DOUT = dout_r;
  assign CUR_ADDR = xAddr_s;
  assign CH_EN    = chEn_r;
  assign TC       = tc_r;
  assign EOP      = eop_r;
endmodule
